multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main control FSM for the lab MIPS datapath. It decodes the 6-bit opcode from the instruction register and sequences each instruction through fetch, decode, execute, memory and write-back. It drives all datapath enables plus the 3-bit `ALUOp` bus consumed by the ALU control decoder. Memory accesses use a ready handshake, so fetch and load/store stall on slow memory.

## Interface
- No parameters; opcode and `ALUOp` encodings are fixed below.
- `clk_i` in 1: system clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `instr_op_i` in 6: opcode from the instruction register; stable from DECODE onward.
- `mem_ready_i` in 1: memory completes the current read/write this cycle.
- `mem_read_o` out 1: memory read request (fetch or lw).
- `mem_write_o` out 1: memory write request (sw).
- `iord_o` out 1: address select; 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: load instruction register.
- `pc_write_o` out 1: unconditional PC write.
- `pc_write_cond_o` out 1: conditional PC write, branch.
- `branch_ne_o` out 1: condition polarity; 1 = bne (take if !zero).
- `alu_src_a_o` out 1: 0 = PC, 1 = rs.
- `alu_src_b_o` out 2: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_op_o` out 3: 000 R-type (funct decides), 001 add, 010 beq, 011 bne, 100 lui, 101 ori, 110 sltiu.
- `reg_dst_o` out 1: 1 = rd, 0 = rt.
- `mem_to_reg_o` out 1: 1 = memory data, 0 = ALUOut.
- `reg_write_o` out 1: register file write.
- `retire_o` out 1: one-cycle pulse on the final cycle of each legal instruction.
- `illegal_o` out 1: one-cycle pulse in DECODE on an unsupported opcode.
- `state_o` out 3: current state, for debug.

## Operation
- Supported opcodes:
  - 000000 R-type
  - 001000 addi
  - 000100 beq
  - 000101 bne
  - 001111 lui
  - 001101 ori
  - 001011 sltiu
  - 100011 lw
  - 101011 sw
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Values 5–7 are unreachable and recover to FETCH.
- FETCH:
  - Outputs: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=001.
  - ir_write_o and pc_write_o equal mem_ready_i (Mealy).
  - Holds until mem_ready_i=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=001 (branch target into ALUOut).
  - Legal opcode goes to EXEC.
  - Illegal opcode: illegal_o=1, go to FETCH, no writes.
- EXEC: alu_src_a_o=1 for all opcodes.
  - R-type: alu_src_b_o=00, alu_op_o=000, then WB.
  - addi/lui/ori/sltiu: alu_src_b_o=10, alu_op_o=001/100/101/110 respectively, then WB.
  - lw/sw: alu_src_b_o=10, alu_op_o=001, then MEM.
  - beq/bne: alu_src_b_o=00, alu_op_o=010/011, pc_write_cond_o=1, branch_ne_o=(op==bne), retire_o=1, then FETCH.
- MEM:
  - Outputs: iord_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw.
  - Request is held until mem_ready_i=1.
  - On ready: sw asserts retire_o and goes to FETCH; lw goes to WB.
- WB:
  - Outputs: reg_write_o=1, retire_o=1, then FETCH.
  - reg_dst_o=1 only for R-type.
  - mem_to_reg_o=1 only for lw.
- Unlisted outputs are 0 in every state. alu_op_o defaults to 001.

## Timing
- Reset: on a clock edge with rst_i=1, state goes to FETCH. This overrides any in-progress state, including a stalled MEM with mem_write_o high.
- After reset all enables are 0 except FETCH's Moore outputs: mem_read_o=1, alu_src_b_o=01, alu_op_o=001.
- Latency with mem_ready_i tied high:
  - branch: 3 cycles
  - R/I-type: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each stall cycle in FETCH or MEM adds 1 cycle.
- Handshake:
  - A request stays asserted with constant iord_o until the cycle mem_ready_i=1.
  - The transfer completes in that same cycle.
  - No request is issued in DECODE, EXEC or WB.
  - mem_ready_i is ignored outside FETCH and MEM.
- ir_write_o and pc_write_o pulse for exactly one cycle per fetch, never during stall cycles.
- retire_o and illegal_o are mutually exclusive; exactly one pulses per fetched instruction.
- instr_op_i is sampled combinationally in DECODE, EXEC, MEM and WB. It must not change between DECODE and the return to FETCH.

## Test plan
- Reset mid-operation: rst_i=1 for 1 cycle during a MEM stall -> next cycle state_o=0, mem_write_o=0, mem_read_o=1, reg_write_o=0.
- R-type, op=000000, mem_ready_i=1 -> state_o sequence 0,1,2,4,0.
  - alu_op_o=000 in EXEC.
  - reg_write_o=1 and reg_dst_o=1 in WB.
  - retire_o pulses once, in cycle 4.
- lw with fetch stalled 2 cycles and MEM stalled 1 cycle -> total 8 cycles.
  - ir_write_o high only in the 3rd FETCH cycle.
  - mem_to_reg_o=1 and reg_write_o=1 in WB.
- bne, op=000101 -> in EXEC: alu_op_o=011, pc_write_cond_o=1, branch_ne_o=1, retire_o=1; back in FETCH on cycle 4.
- Sweep ori/lui/sltiu/addi -> EXEC alu_op_o = 101/100/110/001 respectively, alu_src_b_o=10, reg_dst_o=0 in WB.
- Illegal op=111111 -> illegal_o=1 in DECODE, returns to FETCH next cycle.
  - reg_write_o, mem_write_o, pc_write_cond_o never asserted.
  - retire_o stays 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for the multi-cycle MIPS datapath. The FSM decodes the
// opcode held in the instruction register and steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB. It drives every datapath enable and the
// 3-bit ALU operation bus that feeds the ALU control decoder. Memory accesses
// in FETCH and MEM stall until the memory raises mem_ready_i.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            synchronous, active-high reset (state returns to FETCH)
//   instr_op_i       6-bit opcode from the IR, stable from DECODE onward
//   mem_ready_i      memory completes the current read/write this cycle
//   mem_read_o       memory read request (fetch or lw)
//   mem_write_o      memory write request (sw)
//   iord_o           memory address select: 0 = PC, 1 = ALUOut
//   ir_write_o       load the instruction register
//   pc_write_o       unconditional PC write
//   pc_write_cond_o  conditional PC write for branches
//   branch_ne_o      branch polarity: 1 = take when !zero (bne)
//   alu_src_a_o      ALU A select: 0 = PC, 1 = rs
//   alu_src_b_o      ALU B select: 00 rt, 01 const 4, 10 simm, 11 simm<<2
//   alu_op_o         ALU operation class for the ALU control decoder
//   reg_dst_o        register destination: 1 = rd, 0 = rt
//   mem_to_reg_o     write-back source: 1 = memory data, 0 = ALUOut
//   reg_write_o      register file write
//   retire_o         pulse on the final cycle of each legal instruction
//   illegal_o        pulse in DECODE on an unsupported opcode
//   state_o          current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_BEQ   = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_SLTIU = 3'b110;

    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMX4 = 2'b11;

    state_t state;

    // Opcode class flags.
    logic is_rtype, is_addi, is_beq, is_bne, is_lui, is_ori, is_sltiu;
    logic is_lw, is_sw, is_branch, is_legal;

    assign is_rtype  = (instr_op_i == OP_RTYPE);
    assign is_addi   = (instr_op_i == OP_ADDI);
    assign is_beq    = (instr_op_i == OP_BEQ);
    assign is_bne    = (instr_op_i == OP_BNE);
    assign is_lui    = (instr_op_i == OP_LUI);
    assign is_ori    = (instr_op_i == OP_ORI);
    assign is_sltiu  = (instr_op_i == OP_SLTIU);
    assign is_lw     = (instr_op_i == OP_LW);
    assign is_sw     = (instr_op_i == OP_SW);
    assign is_branch = is_beq | is_bne;
    assign is_legal  = is_rtype | is_addi | is_branch | is_lui | is_ori |
                       is_sltiu | is_lw | is_sw;

    // State register. Reset is synchronous and overrides every state,
    // including a MEM stall with a write request outstanding.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (mem_ready_i) state <= DECODE;
                DECODE:  state <= is_legal ? EXEC : FETCH;
                EXEC: begin
                    if (is_branch)          state <= FETCH;
                    else if (is_lw | is_sw) state <= MEM;
                    else                    state <= WB;
                end
                MEM:     if (mem_ready_i) state <= is_lw ? WB : FETCH;
                WB:      state <= FETCH;
                // Encodings 5-7 are unreachable; recover to FETCH.
                default: state <= FETCH;
            endcase
        end
    end

    assign state_o = state;

    // Outputs are decoded from the current state in the same cycle: the
    // opcode is only guaranteed valid combinationally from DECODE on, and
    // the IR/PC write strobes and sw retire follow mem_ready_i (Mealy), so a
    // registered copy would be a cycle late.
    // NOTE: every output gets a default before the case statement so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRC_B_RT;
        alu_op_o        = ALU_ADD;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        retire_o        = 1'b0;
        illegal_o       = 1'b0;

        case (state)
            FETCH: begin
                // PC + 4 computed while the instruction is read; IR and PC
                // load only on the cycle the read completes.
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            DECODE: begin
                // Branch target PC + (simm << 2) is latched into ALUOut.
                alu_src_b_o = SRC_B_IMMX4;
                illegal_o   = ~is_legal;
            end
            EXEC: begin
                alu_src_a_o = 1'b1;
                if (is_rtype) begin
                    alu_src_b_o = SRC_B_RT;
                    alu_op_o    = ALU_FUNCT;
                end else if (is_branch) begin
                    alu_src_b_o     = SRC_B_RT;
                    alu_op_o        = is_bne ? ALU_BNE : ALU_BEQ;
                    pc_write_cond_o = 1'b1;
                    branch_ne_o     = is_bne;
                    retire_o        = 1'b1;
                end else begin
                    alu_src_b_o = SRC_B_IMM;
                    if (is_lui)        alu_op_o = ALU_LUI;
                    else if (is_ori)   alu_op_o = ALU_ORI;
                    else if (is_sltiu) alu_op_o = ALU_SLTIU;
                    else               alu_op_o = ALU_ADD;
                end
            end
            MEM: begin
                iord_o      = 1'b1;
                mem_read_o  = is_lw;
                mem_write_o = is_sw;
                retire_o    = is_sw & mem_ready_i;
            end
            WB: begin
                reg_write_o  = 1'b1;
                retire_o     = 1'b1;
                reg_dst_o    = is_rtype;
                mem_to_reg_o = is_lw;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. The driver issues one instruction at a
// time (opcode plus fetch/MEM stall counts) and pushes the expected
// per-instruction summary, derived from the instruction-class rules, into a
// queue. An independent monitor accumulates what the DUT does cycle by cycle
// and, on each retire_o / illegal_o pulse, pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instr_op;
    logic       mem_ready;
    logic       mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
    logic       pc_write_cond_o, branch_ne_o, alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_op_i      (instr_op),
        .mem_ready_i     (mem_ready),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .iord_o          (iord_o),
        .ir_write_o      (ir_write_o),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .branch_ne_o     (branch_ne_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .reg_dst_o       (reg_dst_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .retire_o        (retire_o),
        .illegal_o       (illegal_o),
        .state_o         (state_o)
    );

    // Per-instruction summary, from the first FETCH cycle to the retire or
    // illegal pulse inclusive.
    typedef struct {
        bit          illegal;
        int          cycles;
        logic [63:0] trace;      // state_o per cycle, 3 bits each, oldest first
        int          n_ir;
        int          n_pc;
        int          n_rd;
        int          n_wr;
        int          n_rw;
        int          n_cond;
        int          ir_at;      // cycle index of the IR write
        int          fetch_bad;  // FETCH cycles with wrong Moore outputs
        int          dec_bad;    // DECODE cycles with wrong outputs
        logic [2:0]  exec_op;
        logic [1:0]  exec_b;
        bit          exec_a;
        bit          any_rd;     // reg_dst_o seen at any cycle
        bit          any_m2r;    // mem_to_reg_o seen at any cycle
        bit          any_bne;    // branch_ne_o seen at any cycle
    } txn_t;

    int   total = 0;
    int   bad   = 0;
    txn_t exp_q[$];
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: what one instruction should look like, from the
    // instruction-class rules.
    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_BR = 3, K_LW = 4, K_SW = 5;

    function automatic txn_t model(input logic [5:0] op, input int fs,
                                   input int ms);
        txn_t t;
        int   kind;
        logic [2:0] aop;
        int   st[$];
        t = '{default: 0};
        aop = 3'b001;
        case (op)
            6'b000000: begin kind = K_R;  aop = 3'b000; end
            6'b001000: begin kind = K_I;  aop = 3'b001; end
            6'b001111: begin kind = K_I;  aop = 3'b100; end
            6'b001101: begin kind = K_I;  aop = 3'b101; end
            6'b001011: begin kind = K_I;  aop = 3'b110; end
            6'b000100: begin kind = K_BR; aop = 3'b010; end
            6'b000101: begin kind = K_BR; aop = 3'b011; end
            6'b100011: begin kind = K_LW; aop = 3'b001; end
            6'b101011: begin kind = K_SW; aop = 3'b001; end
            default:   kind = K_ILL;
        endcase
        for (int i = 0; i <= fs; i++) st.push_back(0);
        st.push_back(1);
        if (kind != K_ILL) st.push_back(2);
        if (kind == K_LW || kind == K_SW)
            for (int i = 0; i <= ms; i++) st.push_back(3);
        if (kind == K_R || kind == K_I || kind == K_LW) st.push_back(4);
        foreach (st[i]) t.trace = (t.trace << 3) | 64'(st[i]);
        t.cycles  = st.size();
        t.illegal = (kind == K_ILL);
        t.n_ir    = 1;
        t.n_pc    = 1;
        t.ir_at   = fs;
        t.n_rd    = fs + 1 + ((kind == K_LW) ? ms + 1 : 0);
        t.n_wr    = (kind == K_SW) ? ms + 1 : 0;
        t.n_rw    = (kind == K_R || kind == K_I || kind == K_LW) ? 1 : 0;
        t.n_cond  = (kind == K_BR) ? 1 : 0;
        if (kind != K_ILL) begin
            t.exec_op = aop;
            t.exec_b  = (kind == K_R || kind == K_BR) ? 2'b00 : 2'b10;
            t.exec_a  = 1'b1;
        end
        t.any_rd  = (kind == K_R);
        t.any_m2r = (kind == K_LW);
        t.any_bne = (op == 6'b000101);
        return t;
    endfunction

    task automatic compare_txn(input txn_t e, input txn_t g);
        check("kind_illegal", g.illegal, e.illegal);
        check("cycles",       g.cycles,  e.cycles);
        check("state_trace",  g.trace,   e.trace);
        check("ir_write_cnt", g.n_ir,    e.n_ir);
        check("pc_write_cnt", g.n_pc,    e.n_pc);
        check("ir_write_at",  g.ir_at,   e.ir_at);
        check("mem_read_cyc", g.n_rd,    e.n_rd);
        check("mem_write_cyc", g.n_wr,   e.n_wr);
        check("reg_write_cnt", g.n_rw,   e.n_rw);
        check("pc_cond_cnt",  g.n_cond,  e.n_cond);
        check("fetch_outputs", g.fetch_bad, e.fetch_bad);
        check("decode_outputs", g.dec_bad, e.dec_bad);
        check("exec_alu_op",  g.exec_op, e.exec_op);
        check("exec_src_b",   g.exec_b,  e.exec_b);
        check("exec_src_a",   g.exec_a,  e.exec_a);
        check("reg_dst",      g.any_rd,  e.any_rd);
        check("mem_to_reg",   g.any_m2r, e.any_m2r);
        check("branch_ne",    g.any_bne, e.any_bne);
    endtask

    // Monitor: samples on the falling edge, away from input changes.
    initial begin : monitor
        txn_t got;
        txn_t e;
        got = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                got = '{default: 0};
            end else begin
                if (ir_write_o) got.ir_at = got.cycles;
                got.trace  = (got.trace << 3) | 64'(state_o);
                got.cycles = got.cycles + 1;
                got.n_ir   = got.n_ir   + int'(ir_write_o);
                got.n_pc   = got.n_pc   + int'(pc_write_o);
                got.n_rd   = got.n_rd   + int'(mem_read_o);
                got.n_wr   = got.n_wr   + int'(mem_write_o);
                got.n_rw   = got.n_rw   + int'(reg_write_o);
                got.n_cond = got.n_cond + int'(pc_write_cond_o);
                if (state_o == 3'd0 &&
                    !(mem_read_o && !iord_o && !alu_src_a_o &&
                      alu_src_b_o == 2'b01 && alu_op_o == 3'b001))
                    got.fetch_bad++;
                if (state_o == 3'd1 &&
                    !(!mem_read_o && !mem_write_o && !alu_src_a_o &&
                      alu_src_b_o == 2'b11 && alu_op_o == 3'b001))
                    got.dec_bad++;
                if (state_o == 3'd2) begin
                    got.exec_op = alu_op_o;
                    got.exec_b  = alu_src_b_o;
                    got.exec_a  = alu_src_a_o;
                end
                got.any_rd  = got.any_rd  | reg_dst_o;
                got.any_m2r = got.any_m2r | mem_to_reg_o;
                got.any_bne = got.any_bne | branch_ne_o;
                if (retire_o || illegal_o) begin
                    check("retire_illegal_excl", retire_o & illegal_o, 0);
                    got.illegal = illegal_o;
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        compare_txn(e, got);
                    end
                    got = '{default: 0};
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive one instruction: mem_ready_i answers each memory request after
    // the requested number of stall cycles and is random elsewhere.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        bit fetched;
        bit done;
        int fl;
        int ml;
        exp_q.push_back(model(op, fs, ms));
        instr_op = op;
        fetched  = 1'b0;
        done     = 1'b0;
        fl       = fs;
        ml       = ms;
        for (int c = 0; c < 40; c++) begin
            if (fetched && state_o == 3'd0) begin
                done = 1'b1;
                break;
            end
            if (mem_read_o && !iord_o) begin
                mem_ready = (fl == 0);
                if (fl == 0) fetched = 1'b1;
                fl--;
            end else if ((mem_read_o || mem_write_o) && iord_o) begin
                mem_ready = (ml == 0);
                ml--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check("instr_timeout", 0, 1);
            mon_en = 1'b0;
            do_reset();
            exp_q.delete();
            mon_en = 1'b1;
        end
    endtask

    logic [5:0] legal_ops [9] = '{6'b000000, 6'b001000, 6'b000100,
                                  6'b000101, 6'b001111, 6'b001101,
                                  6'b001011, 6'b100011, 6'b101011};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [5:0] op;
        instr_op = 6'b000000;
        do_reset();

        // Reset state: only FETCH's Moore outputs are active.
        check("rst_state",      state_o,         0);
        check("rst_mem_read",   mem_read_o,      1);
        check("rst_alu_src_b",  alu_src_b_o,     2'b01);
        check("rst_alu_op",     alu_op_o,        3'b001);
        check("rst_ir_write",   ir_write_o,      0);
        check("rst_pc_write",   pc_write_o,      0);
        check("rst_mem_write",  mem_write_o,     0);
        check("rst_reg_write",  reg_write_o,     0);
        check("rst_iord",       iord_o,          0);
        check("rst_retire",     retire_o | illegal_o, 0);

        // Reset during a stalled sw in MEM.
        instr_op  = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk); #1;                 // DECODE
        mem_ready = 1'b0;
        @(posedge clk); #1;                 // EXEC
        @(posedge clk); #1;                 // MEM, stalled
        check("mid_mem_state", state_o,     3);
        check("mid_mem_write", mem_write_o, 1);
        @(posedge clk); #1;                 // still stalled
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_state",     state_o,     0);
        check("post_rst_mem_write", mem_write_o, 0);
        check("post_rst_mem_read",  mem_read_o,  1);
        check("post_rst_reg_write", reg_write_o, 0);

        mon_en = 1'b1;

        // Directed cases.
        run_instr(6'b000000, 0, 0);         // R-type: 0,1,2,4
        run_instr(6'b100011, 2, 1);         // lw, 8 cycles
        run_instr(6'b000101, 0, 0);         // bne
        run_instr(6'b000100, 1, 0);         // beq
        run_instr(6'b001101, 0, 0);         // ori
        run_instr(6'b001111, 0, 0);         // lui
        run_instr(6'b001011, 0, 0);         // sltiu
        run_instr(6'b001000, 0, 0);         // addi
        run_instr(6'b111111, 1, 0);         // illegal
        run_instr(6'b101011, 0, 2);         // sw, stalled MEM
        run_instr(6'b101011, 0, 0);         // sw, 4 cycles

        // Randomized mix, including arbitrary opcodes.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 8)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
